// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: field widths, legal oversampling
// ratios and the check that decides whether a ratio is usable.
package uart_rx_pkg;

   localparam int PRESCALE_W = 6;

   localparam int unsigned PRESCALE_8  = 8;
   localparam int unsigned PRESCALE_16 = 16;
   localparam int unsigned PRESCALE_32 = 32;

   // Only power-of-two ratios with a clean mid-bit point are supported.
   function automatic logic prescale_legal(input int unsigned p);
      return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
   endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the raw serial line. Resets to 1 so an idle
// (high) line does not look like a start bit right after reset.
module rx_sync (
   input  logic rx_sync_clk,
   input  logic rx_sync_rst,
   input  logic async_in,
   output logic sync_out
);

   logic meta;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge rx_sync_clk or negedge rx_sync_rst) begin
      if (!rx_sync_rst) begin
         meta     <= 1'b1;
         sync_out <= 1'b1;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/data_sampling.sv
// UART receive oversampling front end. Counts oversampling edges within a
// bit, takes three samples around mid-bit and emits a 2-of-3 majority bit
// with a one-cycle valid strobe.
module data_sampling #(
   parameter int PRESCALE_W = uart_rx_pkg::PRESCALE_W
) (
   input  logic                  data_sampling_clk,
   input  logic                  data_sampling_rst,
   input  logic                  rx_in,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  dat_samp_en,
   output logic                  sampled_bit,
   output logic                  sample_valid,
   output logic [PRESCALE_W-1:0] edge_cnt,
   output logic                  bit_done,
   output logic                  prescale_err
);

   import uart_rx_pkg::*;

   localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);
   localparam logic [PRESCALE_W-1:0] P_RESET  = PRESCALE_W'(PRESCALE_8);

   logic                  rx_s;
   logic [PRESCALE_W-1:0] prescale_q;
   logic [PRESCALE_W-1:0] cnt_q;
   logic [PRESCALE_W-1:0] mid;
   logic [PRESCALE_W-1:0] p_last;
   logic                  run;
   logic                  s0, s1;
   logic                  vote;

   rx_sync u_rx_sync (
      .rx_sync_clk (data_sampling_clk),
      .rx_sync_rst (data_sampling_rst),
      .async_in    (rx_in),
      .sync_out    (rx_s)
   );

   // The counter and sampler only advance when enabled with a usable ratio.
   assign prescale_err = !prescale_legal(32'(prescale_q));
   assign run          = dat_samp_en & ~prescale_err;
   assign mid          = prescale_q >> 1;
   assign p_last       = prescale_q - ONE;
   assign vote         = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

   assign edge_cnt     = cnt_q;
   assign bit_done     = run & (cnt_q == p_last);

   // Ratio follows the input between frames and is frozen for a whole frame.
   always_ff @(posedge data_sampling_clk or negedge data_sampling_rst) begin
      if (!data_sampling_rst)
         prescale_q <= P_RESET;
      else if (!dat_samp_en)
         prescale_q <= prescale;
   end

   // Edge counter: 0..P-1 while running, parked at 0 otherwise so a new
   // frame always starts at edge 0.
   always_ff @(posedge data_sampling_clk or negedge data_sampling_rst) begin
      if (!data_sampling_rst)
         cnt_q <= '0;
      else if (!run || (cnt_q == p_last))
         cnt_q <= '0;
      else
         cnt_q <= cnt_q + ONE;
   end

   // Mid-bit sample capture; a partial bit is thrown away when disabled.
   always_ff @(posedge data_sampling_clk or negedge data_sampling_rst) begin
      if (!data_sampling_rst) begin
         s0 <= 1'b0;
         s1 <= 1'b0;
      end else if (!run) begin
         s0 <= 1'b0;
         s1 <= 1'b0;
      end else begin
         if (cnt_q == (mid - ONE)) s0 <= rx_s;
         if (cnt_q == mid)         s1 <= rx_s;
      end
   end

   // Majority vote on the third sample; the bit holds between votes.
   always_ff @(posedge data_sampling_clk or negedge data_sampling_rst) begin
      if (!data_sampling_rst) begin
         sampled_bit  <= 1'b0;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= run & (cnt_q == (mid + ONE));
         if (run && (cnt_q == (mid + ONE)))
            sampled_bit <= vote;
      end
   end

endmodule

// File: tb/tb_data_sampling.sv
// Directed bench for data_sampling: expected votes are queued with the
// cycle and edge index they must appear at, and popped whenever the DUT
// raises sample_valid.
module tb_data_sampling;

   localparam int W = 6;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         rx_in;
   logic [W-1:0] prescale;
   logic         en;
   logic         sampled_bit;
   logic         sample_valid;
   logic [W-1:0] edge_cnt;
   logic         bit_done;
   logic         prescale_err;

   typedef struct {
      logic b;
      int   at;
      int   cnt;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   ncyc  = 0;
   int   t0    = 0;

   data_sampling #(.PRESCALE_W(W)) dut (
      .data_sampling_clk (clk),
      .data_sampling_rst (rst_n),
      .rx_in             (rx_in),
      .prescale          (prescale),
      .dat_samp_en       (en),
      .sampled_bit       (sampled_bit),
      .sample_valid      (sample_valid),
      .edge_cnt          (edge_cnt),
      .bit_done          (bit_done),
      .prescale_err      (prescale_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and score any valid strobe.
   task automatic cyc();
      exp_t e;
      @(negedge clk);
      ncyc++;
      chk("valid_and_done_overlap", int'(sample_valid & bit_done), 0);
      if (sample_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("valid_with_empty_scoreboard", sb.size(), 1);
         end else begin
            e = sb.pop_front();
            chk("valid_cycle", ncyc, e.at);
            chk("sampled_bit", int'(sampled_bit), int'(e.b));
            chk("valid_edge_cnt", int'(edge_cnt), e.cnt);
         end
      end
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic enable();
      en = 1'b1;
      t0 = ncyc;
   endtask

   task automatic push(input logic b, input int at, input int cnt);
      exp_t e;
      e.b = b; e.at = at; e.cnt = cnt;
      sb.push_back(e);
   endtask

   initial begin
      rst_n = 1'b0; rx_in = 1'b1; en = 1'b0; prescale = 6'd8;
      run_cycles(2);
      chk("rst_sampled_bit",  int'(sampled_bit), 0);
      chk("rst_sample_valid", int'(sample_valid), 0);
      chk("rst_edge_cnt",     int'(edge_cnt), 0);
      chk("rst_bit_done",     int'(bit_done), 0);
      chk("rst_prescale_err", int'(prescale_err), 0);
      rst_n = 1'b1;

      // Steady low line, P = 8
      rx_in = 1'b0;
      run_cycles(4);
      enable();
      push(1'b0, t0 + 6, 6); push(1'b0, t0 + 14, 6); push(1'b0, t0 + 22, 6);
      for (int k = 1; k <= 24; k++) begin
         cyc();
         chk("p8_edge_cnt", int'(edge_cnt), k % 8);
         chk("p8_bit_done", int'(bit_done), int'((k % 8) == 7));
      end
      en = 1'b0;
      cyc();
      chk("p8_cnt_after_disable", int'(edge_cnt), 0);
      chk("p8_scoreboard_drained", sb.size(), 0);

      // Glitch rejection, P = 16: rx_s low only at edge 8
      rx_in = 1'b1; prescale = 6'd16;
      run_cycles(4);
      enable();
      push(1'b1, t0 + 10, 10);
      for (int k = 1; k <= 16; k++) begin
         cyc();
         if (k == 15) chk("p16_bit_done", int'(bit_done), 1);
         if (k == 6) rx_in = 1'b0;
         if (k == 7) rx_in = 1'b1;
      end
      en = 1'b0;
      run_cycles(2);

      // Two of three low, P = 16: rx_s low at edges 7 and 9
      enable();
      push(1'b0, t0 + 10, 10);
      for (int k = 1; k <= 16; k++) begin
         cyc();
         if (k == 5) rx_in = 1'b0;
         if (k == 6) rx_in = 1'b1;
         if (k == 7) rx_in = 1'b0;
         if (k == 8) rx_in = 1'b1;
      end
      en = 1'b0;
      run_cycles(2);
      chk("vote_scoreboard_drained", sb.size(), 0);

      // Prescale frozen while enabled
      prescale = 6'd8;
      run_cycles(2);
      enable();
      push(1'b1, t0 + 6, 6); push(1'b1, t0 + 14, 6);
      for (int k = 1; k <= 16; k++) begin
         cyc();
         if (k == 2) prescale = 6'd16;
         chk("freeze_bit_done", int'(bit_done), int'((k % 8) == 7));
      end
      en = 1'b0;
      run_cycles(2);
      enable();
      push(1'b1, t0 + 10, 10); push(1'b1, t0 + 26, 10);
      run_cycles(32);
      en = 1'b0;
      run_cycles(2);
      chk("freeze_scoreboard_drained", sb.size(), 0);

      // Illegal prescale
      prescale = 6'd12;
      run_cycles(2);
      chk("illegal_err_set", int'(prescale_err), 1);
      enable();
      for (int k = 1; k <= 50; k++) begin
         cyc();
         chk("illegal_edge_cnt", int'(edge_cnt), 0);
         chk("illegal_bit_done", int'(bit_done), 0);
      end
      en = 1'b0;
      prescale = 6'd8;
      run_cycles(2);
      chk("illegal_err_clear", int'(prescale_err), 0);

      // Abort mid-bit at edge 4
      rx_in = 1'b0;
      run_cycles(3);
      chk("abort_bit_before", int'(sampled_bit), 1);
      enable();
      run_cycles(4);
      chk("abort_edge_at_drop", int'(edge_cnt), 4);
      en = 1'b0;
      cyc();
      chk("abort_cnt_cleared", int'(edge_cnt), 0);
      chk("abort_bit_held", int'(sampled_bit), 1);
      run_cycles(8);
      chk("abort_bit_still_held", int'(sampled_bit), 1);

      // Asynchronous reset mid-bit at edge 5
      enable();
      run_cycles(5);
      chk("reset_edge_before", int'(edge_cnt), 5);
      chk("reset_bit_before", int'(sampled_bit), 1);
      rst_n = 1'b0;
      #1;
      chk("reset_sampled_bit",  int'(sampled_bit), 0);
      chk("reset_sample_valid", int'(sample_valid), 0);
      chk("reset_edge_cnt",     int'(edge_cnt), 0);
      chk("reset_bit_done",     int'(bit_done), 0);
      chk("reset_prescale_err", int'(prescale_err), 0);
      cyc();
      rst_n = 1'b1;
      t0 = ncyc;
      push(1'b0, t0 + 6, 6);
      for (int k = 1; k <= 8; k++) begin
         cyc();
         chk("post_reset_edge_cnt", int'(edge_cnt), k % 8);
      end
      en = 1'b0;
      run_cycles(2);
      chk("final_scoreboard_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
